// File: rtl/alu_issuer_pkg.sv
// Shared definitions for the ALU operation issuer: FSM state encoding,
// multiply command codes and default latency values.
package alu_issuer_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_BEAT_A   = 3'd1,
    S_GAP      = 3'd2,
    S_BEAT_B   = 3'd3,
    S_WAIT_RES = 3'd4,
    S_RESP     = 3'd5
  } state_e;

  localparam logic [3:0] CMD_MUL_INC   = 4'd9;
  localparam logic [3:0] CMD_MUL_SHIFT = 4'd10;

  localparam int DEF_LAT     = 1;
  localparam int DEF_MUL_LAT = 2;

  // Multiply commands only exist in arithmetic mode (MODE=1).
  function automatic logic is_mul(input logic mode, input logic [3:0] cmd);
    return mode && ((cmd == CMD_MUL_INC) || (cmd == CMD_MUL_SHIFT));
  endfunction

endpackage

// File: rtl/alu_op_issuer.sv
// ALU operation issuer: accepts one request at a time, presents its operands
// to the ALU in one beat (split=0) or two beats separated by req_gap idle
// cycles (split=1), waits the command's fixed result latency, captures the
// ALU result and flags and holds them until the consumer takes them.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   req_valid/req_ready      request handshake (ready only in IDLE)
//   req_mode/cin/cmd/opa/opb ALU command fields, registered at acceptance
//   req_split, req_gap       two-beat delivery and idle cycles between beats
//   CE..INP_VALID            drive side of the ALU
//   RES, ERR..E              ALU result and flags
//   rsp_valid/rsp_ready      response handshake
//   rsp_res, rsp_flags       captured RES and {ERR,OFLOW,COUT,G,L,E}
module alu_op_issuer
  import alu_issuer_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LAT        = DEF_LAT,
  parameter int MUL_LAT    = DEF_MUL_LAT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_mode,
  input  logic                  req_cin,
  input  logic [3:0]            req_cmd,
  input  logic [DATA_WIDTH-1:0] req_opa,
  input  logic [DATA_WIDTH-1:0] req_opb,
  input  logic                  req_split,
  input  logic [3:0]            req_gap,
  output logic                  CE,
  output logic                  MODE,
  output logic                  CIN,
  output logic [3:0]            CMD,
  output logic [DATA_WIDTH-1:0] OPA,
  output logic [DATA_WIDTH-1:0] OPB,
  output logic [1:0]            INP_VALID,
  input  logic [DATA_WIDTH+1:0] RES,
  input  logic                  ERR,
  input  logic                  OFLOW,
  input  logic                  COUT,
  input  logic                  G,
  input  logic                  L,
  input  logic                  E,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH+1:0] rsp_res,
  output logic [5:0]            rsp_flags
);

  // One counter serves both the gap and the result latency; the phases never
  // overlap. It must hold max(latency)-1 and 14 (gap-1).
  localparam int MAX_LAT = (LAT > MUL_LAT) ? LAT : MUL_LAT;
  localparam int CNT_W   = ($clog2(MAX_LAT) > 4) ? $clog2(MAX_LAT) : 4;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  mode_q, mode_d;
  logic                  cin_q, cin_d;
  logic [3:0]            cmd_q, cmd_d;
  logic [DATA_WIDTH-1:0] opa_q, opa_d;
  logic [DATA_WIDTH-1:0] opb_q, opb_d;
  logic [3:0]            gap_q, gap_d;
  logic [DATA_WIDTH+1:0] res_q, res_d;
  logic [5:0]            flags_q, flags_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      cin_q   <= 1'b0;
      cmd_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      gap_q   <= '0;
      res_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      cin_q   <= cin_d;
      cmd_q   <= cmd_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      gap_q   <= gap_d;
      res_q   <= res_d;
      flags_q <= flags_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mode_d    = mode_q;
    cin_d     = cin_q;
    cmd_d     = cmd_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    gap_d     = gap_q;
    res_d     = res_q;
    flags_d   = flags_q;
    CE        = 1'b0;
    MODE      = 1'b0;
    CIN       = 1'b0;
    CMD       = '0;
    OPA       = '0;
    OPB       = '0;
    INP_VALID = 2'b00;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          mode_d  = req_mode;
          cin_d   = req_cin;
          cmd_d   = req_cmd;
          opa_d   = req_opa;
          opb_d   = req_opb;
          gap_d   = req_gap;
          state_d = req_split ? S_BEAT_A : S_BEAT_B;
        end
      end
      // BEAT_A and GAP present the same first beat; GAP just stretches it.
      S_BEAT_A, S_GAP: begin
        CE        = 1'b1;
        INP_VALID = 2'b01;
        OPA       = opa_q;
        MODE      = mode_q;
        CIN       = cin_q;
        CMD       = cmd_q;
        if (state_q == S_BEAT_A) begin
          if (gap_q != 4'd0) begin
            cnt_d   = CNT_W'(gap_q - 4'd1);
            state_d = S_GAP;
          end else begin
            state_d = S_BEAT_B;
          end
        end else if (cnt_q == '0) begin
          state_d = S_BEAT_B;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_BEAT_B: begin
        CE        = 1'b1;
        INP_VALID = 2'b11;
        OPA       = opa_q;
        OPB       = opb_q;
        MODE      = mode_q;
        CIN       = cin_q;
        CMD       = cmd_q;
        // Loaded with N-1 so the capture lands on the edge ending cycle T+N.
        cnt_d     = is_mul(mode_q, cmd_q) ? CNT_W'(MUL_LAT - 1) : CNT_W'(LAT - 1);
        state_d   = S_WAIT_RES;
      end
      S_WAIT_RES: begin
        MODE = mode_q;
        CIN  = cin_q;
        CMD  = cmd_q;
        if (cnt_q == '0) begin
          res_d   = RES;
          flags_d = {ERR, OFLOW, COUT, G, L, E};
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Gated with rst so ready stays low while reset is held.
  assign req_ready = rst && (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_res   = res_q;
  assign rsp_flags = flags_q;

endmodule

// File: doc/alu_op_issuer.md
ALU_OP_ISSUER -- requirements
Module: alu_op_issuer

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the operand width; result width is DATA_WIDTH+2.
REQ-002 Parameter LAT, default 1, SHALL be the ALU result latency in cycles for non-multiply commands.
REQ-003 Parameter MUL_LAT, default 2, SHALL be the ALU result latency for MODE=1, CMD=9 or CMD=10.
REQ-004 Ports SHALL be:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  request offered.
- req_ready  out  1  issuer accepts request.
- req_mode, req_cin  in  1 each  ALU MODE, CIN.
- req_cmd  in  4  ALU CMD.
- req_opa, req_opb  in  DATA_WIDTH  operands.
- req_split  in  1  deliver operands in two beats.
- req_gap  in  4  idle cycles between beats, 0..15.
- CE, MODE, CIN  out  1 each  to ALU.
- CMD  out  4  to ALU.
- OPA, OPB  out  DATA_WIDTH  to ALU.
- INP_VALID  out  2  to ALU.
- RES  in  DATA_WIDTH+2  from ALU.
- ERR, OFLOW, COUT, G, L, E  in  1 each  from ALU.
- rsp_valid  out  1  response held.
- rsp_ready  in  1  response consumed.
- rsp_res  out  DATA_WIDTH+2  captured RES.
- rsp_flags  out  6  captured {ERR,OFLOW,COUT,G,L,E}.

Function
REQ-005 The FSM SHALL have states IDLE, BEAT_A, GAP, BEAT_B, WAIT_RES and RESP.
REQ-006 req_ready SHALL be high only in IDLE; a request SHALL be accepted on a clock edge where req_valid and req_ready are both high.
REQ-007 On acceptance with req_split=0, the next cycle SHALL be BEAT_B.
REQ-008 On acceptance with req_split=1, the next cycle SHALL be BEAT_A.
REQ-009 BEAT_A SHALL drive CE=1, INP_VALID=01, OPA=req_opa and OPB=0; it SHALL go to GAP when req_gap>0, otherwise to BEAT_B.
REQ-010 GAP SHALL hold all BEAT_A outputs for exactly req_gap cycles via a down-counter, then go to BEAT_B.
REQ-011 BEAT_B SHALL last one cycle with CE=1, INP_VALID=11, OPA, OPB, CIN, MODE and CMD from the request, then go to WAIT_RES.
REQ-012 MODE, CMD and CIN SHALL be constant from BEAT_A or BEAT_B through the end of WAIT_RES.
REQ-013 WAIT_RES SHALL drive CE=0 and INP_VALID=00.
REQ-014 If BEAT_B occupies cycle T, RES and the flags SHALL be captured on the edge ending cycle T+N, where N is MUL_LAT for multiply commands and LAT otherwise; rsp_valid SHALL rise in cycle T+N+1.
REQ-015 The latency counter SHALL be loaded in BEAT_B.
REQ-016 RESP SHALL hold rsp_valid=1 and stable rsp_res and rsp_flags until an edge with rsp_ready=1, then go to IDLE.
REQ-017 rsp_ready=1 in the first RESP cycle SHALL complete the handshake in that cycle.
REQ-018 ALU ERR SHALL be passed through in rsp_flags and SHALL NOT alter sequencing.
REQ-019 req_gap is at most 15, so the issuer SHALL never provoke the ALU 16-cycle wait error.
REQ-020 Request fields SHALL be registered at acceptance; changes on req_* afterwards SHALL have no effect.

Reset
REQ-021 rst low SHALL immediately force IDLE, with CE, MODE, CIN, CMD, OPA, OPB, INP_VALID, rsp_valid, rsp_res, rsp_flags and all counters at 0.
REQ-022 req_ready SHALL be 0 while rst is low and 1 in the first cycle after release.
REQ-023 Reset mid-operation SHALL abandon the operation with no response produced.

Structure
REQ-024 Package alu_issuer_pkg SHALL hold the state enum, the multiply CMD codes (9, 10) and the default LAT and MUL_LAT values.
REQ-025 No sub-module SHALL be used; the issuer is a single module.

Verification
REQ-026 Single-beat add: mode=1, cmd=0, opa=8'h0F, opb=8'h01, split=0 -> one CE=1, INP_VALID=11 cycle; rsp_valid two cycles later; rsp_res=10'h010.
REQ-027 Split with gap: split=1, gap=3 -> INP_VALID=01 for 4 consecutive cycles, then 11 for exactly 1 cycle, then 00.
REQ-028 Multiply: mode=1, cmd=9 -> capture on the MUL_LAT=2 edge; rsp_valid in cycle T+3.
REQ-029 Back-pressure: rsp_ready=0 for 5 cycles -> rsp_valid and rsp_res stable, req_ready=0 throughout; the next request is accepted one cycle after rsp_ready=1.
REQ-030 Rotate error: mode=0, cmd=12, opb=8'h10, with the ALU asserting ERR -> rsp_flags[5]=1.
REQ-031 Reset during GAP: all outputs 0 asynchronously; no rsp_valid; req_ready=1 after release.
